// File: rtl/sound_glu_if.sv
// CPU-side sound register bus ($C03C-$C03F) between the bus decoder and sound_glu.
// Latency: cpu_dout is a combinational function of cpu_addr and the register state.
// Backpressure: none on the bus; the CPU polls CTL bit7 (busy) before issuing DATA accesses.
interface sound_glu_if;
    logic       cpu_sel;
    logic [1:0] cpu_addr;
    logic       cpu_we;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;

    // CPU / bus-decoder side
    modport master (
        output cpu_sel,
        output cpu_addr,
        output cpu_we,
        output cpu_din,
        input  cpu_dout
    );

    // sound_glu side
    modport slave (
        input  cpu_sel,
        input  cpu_addr,
        input  cpu_we,
        input  cpu_din,
        output cpu_dout
    );
endinterface

// File: rtl/sound_glu.sv
// Host front end for the ES5503: CTL/DATA/ADRL/ADRH registers, DOC register and sound-RAM access sequencing.
// Latency: RAM access 2 cycles (3 on a DOC RAM-slot collision); DOC access 2 cycles plus 0-1 cycles waiting for clk_7M_en.
// Backpressure: busy (CTL bit7) is set while an access is in flight; DATA accesses and ADRL/ADRH writes are dropped meanwhile.
// Optional feature: define SOUND_GLU_AUTOINC_EN to make CTL bit5 post-increment the access pointer.
module sound_glu (
    input  logic              CLK_14M,
    input  logic              reset_n,
    input  logic              clk_7M_en,
    sound_glu_if.slave        cpu,
    output logic              doc_wr,
    output logic              doc_host_en,
    output logic [7:0]        doc_reg_addr,
    output logic [7:0]        doc_wdata,
    input  logic [7:0]        doc_rdata,
    input  logic              doc_osc_en,
    input  logic [15:0]       doc_ram_addr,
    output logic [15:0]       ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [3:0]        volume
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DOC_WAIT,
        ST_DOC_ACC,
        ST_DOC_CAP,
        ST_RAM_ACC,
        ST_RAM_CAP
    } state_t;

    localparam logic [1:0] REG_CTL  = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_ADRL = 2'd2;
    localparam logic [1:0] REG_ADRH = 2'd3;

    state_t      state;
    state_t      state_nxt;

    logic        ctl_target;     // 1 = sound RAM, 0 = DOC registers
    logic        ctl_autoinc;
    logic [3:0]  ctl_vol;
    logic [15:0] ptr;
    logic [7:0]  dlatch;
    logic        acc_wr;         // direction of the access in flight

    logic        busy;
    logic        data_acc;
    logic        launch;
    logic        ctl_wr;
    logic        adrl_wr;
    logic        adrh_wr;
    logic        complete;
    logic        unused_din;

    // CTL bits 7 and 4 have no storage; their write data is deliberately dropped.
    assign unused_din = ^{cpu.cpu_din[7], cpu.cpu_din[4]};

    assign busy     = (state != ST_IDLE);
    assign data_acc = cpu.cpu_sel && (cpu.cpu_addr == REG_DATA);
    assign launch   = data_acc && !busy;
    assign ctl_wr   = cpu.cpu_sel && cpu.cpu_we && (cpu.cpu_addr == REG_CTL);
    assign adrl_wr  = cpu.cpu_sel && cpu.cpu_we && (cpu.cpu_addr == REG_ADRL) && !busy;
    assign adrh_wr  = cpu.cpu_sel && cpu.cpu_we && (cpu.cpu_addr == REG_ADRH) && !busy;
    assign complete = (state == ST_DOC_CAP) || (state == ST_RAM_CAP);

    // State register; reset aborts any access in flight.
    always_ff @(posedge CLK_14M) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and access strobes. A DOC launch that already coincides with a
    // 7 MHz enable goes straight to DOC_ACC; otherwise it parks in DOC_WAIT.
    always_comb begin
        state_nxt   = state;
        doc_host_en = 1'b0;
        doc_wr      = 1'b0;
        ram_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    if (ctl_target) begin
                        state_nxt = ST_RAM_ACC;
                    end else if (clk_7M_en) begin
                        state_nxt = ST_DOC_ACC;
                    end else begin
                        state_nxt = ST_DOC_WAIT;
                    end
                end
            end
            ST_DOC_WAIT: begin
                if (clk_7M_en) begin
                    state_nxt = ST_DOC_ACC;
                end
            end
            ST_DOC_ACC: begin
                // Single-cycle host strobe: an OIR read must pop exactly one IRQ.
                doc_host_en = 1'b1;
                doc_wr      = acc_wr;
                state_nxt   = ST_DOC_CAP;
            end
            ST_DOC_CAP: begin
                state_nxt = ST_IDLE;
            end
            ST_RAM_ACC: begin
                // The DOC owns the RAM port during its oscillator slot; retry next cycle.
                if (!doc_osc_en) begin
                    ram_we    = acc_wr;
                    state_nxt = ST_RAM_CAP;
                end
            end
            ST_RAM_CAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Register file, access pointer and data latch.
    always_ff @(posedge CLK_14M) begin
        if (!reset_n) begin
            ctl_target  <= 1'b0;
            ctl_autoinc <= 1'b0;
            ctl_vol     <= 4'd0;
            ptr         <= 16'd0;
            dlatch      <= 8'd0;
            acc_wr      <= 1'b0;
        end else begin
            if (ctl_wr) begin
                ctl_vol <= cpu.cpu_din[3:0];
                // Mode bits are frozen while an access is in flight.
                if (!busy) begin
                    ctl_target  <= cpu.cpu_din[6];
                    ctl_autoinc <= cpu.cpu_din[5];
                end
            end
            if (adrl_wr) begin
                ptr[7:0] <= cpu.cpu_din;
            end
            if (adrh_wr) begin
                ptr[15:8] <= cpu.cpu_din;
            end
            if (launch) begin
                acc_wr <= cpu.cpu_we;
                if (cpu.cpu_we) begin
                    dlatch <= cpu.cpu_din;
                end
            end
            // Reads deliver their result one access late through dlatch.
            if ((state == ST_DOC_CAP) && !acc_wr) begin
                dlatch <= doc_rdata;
            end
            if ((state == ST_RAM_CAP) && !acc_wr) begin
                dlatch <= ram_rdata;
            end
`ifdef SOUND_GLU_AUTOINC_EN
            // Full 16-bit post-increment in both modes; FFFF wraps to 0000.
            if (complete && ctl_autoinc) begin
                ptr <= ptr + 16'd1;
            end
`endif
        end
    end

    // CPU read mux; CTL bit7 shows busy combinationally.
    always_comb begin
        cpu.cpu_dout = 8'h00;
        case (cpu.cpu_addr)
            REG_CTL:  cpu.cpu_dout = {busy, ctl_target, ctl_autoinc, 1'b0, ctl_vol};
            REG_DATA: cpu.cpu_dout = dlatch;
            REG_ADRL: cpu.cpu_dout = ptr[7:0];
            REG_ADRH: cpu.cpu_dout = ptr[15:8];
            default:  cpu.cpu_dout = 8'h00;
        endcase
    end

    // Sound RAM address: the DOC keeps the port except for the host's granted RAM_ACC cycle.
    always_comb begin
        ram_addr = doc_ram_addr;
        if ((state == ST_RAM_ACC) && !doc_osc_en) begin
            ram_addr = ptr;
        end
    end

    // ptr and dlatch cannot change during an access, so these are stable for the strobe.
    assign doc_reg_addr = ptr[7:0];
    assign doc_wdata    = dlatch;
    assign ram_wdata    = dlatch;
    assign volume       = ctl_vol;

endmodule

// File: tb/tb_sound_glu.sv
// Directed bench for sound_glu with queue-based scoreboard.
// Stimulus pushes expected CPU reads, DOC strobes, RAM writes and busy durations; a negedge monitor pops and compares.
// Behavioural DOC register and 64 KB RAM models provide read data.
module tb_sound_glu;

`ifdef SOUND_GLU_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic        CLK_14M = 1'b0;
    logic        reset_n;
    logic        clk_7M_en;
    logic        doc_wr;
    logic        doc_host_en;
    logic [7:0]  doc_reg_addr;
    logic [7:0]  doc_wdata;
    logic [7:0]  doc_rdata;
    logic        doc_osc_en;
    logic [15:0] doc_ram_addr;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [3:0]  volume;

    sound_glu_if cpu();

    sound_glu dut (
        .CLK_14M      (CLK_14M),
        .reset_n      (reset_n),
        .clk_7M_en    (clk_7M_en),
        .cpu          (cpu),
        .doc_wr       (doc_wr),
        .doc_host_en  (doc_host_en),
        .doc_reg_addr (doc_reg_addr),
        .doc_wdata    (doc_wdata),
        .doc_rdata    (doc_rdata),
        .doc_osc_en   (doc_osc_en),
        .doc_ram_addr (doc_ram_addr),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .volume       (volume)
    );

    always #5 CLK_14M = ~CLK_14M;

    typedef struct { logic wr; logic [7:0] addr; logic [7:0] data; } doc_ev_t;
    typedef struct { logic [15:0] addr; logic [7:0] data; } ram_ev_t;

    doc_ev_t    exp_doc[$];
    ram_ev_t    exp_ram[$];
    logic [7:0] exp_rd[$];
    int         exp_lat[$];

    int n_cmp = 0;
    int n_bad = 0;
    int busy_run = 0;

    logic [7:0] mem [0:65535];

    // DOC model: register read data is a fixed function of the address, valid one cycle later.
    always @(posedge CLK_14M) doc_rdata <= doc_reg_addr ^ 8'h5C;

    // Synchronous sound RAM model with 1-cycle read latency.
    always @(posedge CLK_14M) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endfunction

    // Monitor: compares every DUT-side event against the scoreboard queues.
    always @(negedge CLK_14M) begin
        if (cpu.cpu_sel && !cpu.cpu_we) begin
            if (exp_rd.size() == 0) unexpected("cpu_read");
            else chk("cpu_dout", cpu.cpu_dout, exp_rd.pop_front());
        end
        if (doc_host_en) begin
            if (exp_doc.size() == 0) unexpected("doc_host_en");
            else begin
                doc_ev_t e;
                e = exp_doc.pop_front();
                chk("doc_wr", doc_wr, e.wr);
                chk("doc_reg_addr", doc_reg_addr, e.addr);
                chk("doc_wdata", doc_wdata, e.data);
            end
        end else if (doc_wr) begin
            unexpected("doc_wr_without_host_en");
        end
        if (ram_we) begin
            if (exp_ram.size() == 0) unexpected("ram_we");
            else begin
                ram_ev_t r;
                r = exp_ram.pop_front();
                chk("ram_addr", ram_addr, r.addr);
                chk("ram_wdata", ram_wdata, r.data);
            end
        end
        if (doc_osc_en) chk("ram_addr_doc_slot", ram_addr, doc_ram_addr);
        if (dut.busy) begin
            busy_run++;
        end else if (busy_run > 0) begin
            if (exp_lat.size() == 0) unexpected("busy_period");
            else chk("busy_cycles", busy_run, exp_lat.pop_front());
            busy_run = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK_14M);
            #1;
        end
    endtask

    task automatic bus(input logic [1:0] a, input logic we, input logic [7:0] d);
        cpu.cpu_sel  = 1'b1;
        cpu.cpu_addr = a;
        cpu.cpu_we   = we;
        cpu.cpu_din  = d;
        @(posedge CLK_14M);
        #1;
        cpu.cpu_sel  = 1'b0;
        cpu.cpu_addr = 2'd0;
        cpu.cpu_we   = 1'b0;
        cpu.cpu_din  = 8'h00;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus(a, 1'b1, d);
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e);
        exp_rd.push_back(e);
        bus(a, 1'b0, 8'h00);
    endtask

    task automatic push_doc(input logic w, input logic [7:0] a, input logic [7:0] d);
        doc_ev_t e;
        e.wr = w; e.addr = a; e.data = d;
        exp_doc.push_back(e);
    endtask

    task automatic push_ram(input logic [15:0] a, input logic [7:0] d);
        ram_ev_t r;
        r.addr = a; r.data = d;
        exp_ram.push_back(r);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h12FF] = 8'h5A;
        mem[16'h1300] = 8'hC3;

        reset_n      = 1'b0;
        clk_7M_en    = 1'b1;
        doc_osc_en   = 1'b0;
        doc_ram_addr = 16'hBEEF;
        cpu.cpu_sel  = 1'b0;
        cpu.cpu_addr = 2'd0;
        cpu.cpu_we   = 1'b0;
        cpu.cpu_din  = 8'h00;
        idle(3);
        reset_n = 1'b1;
        idle(1);

        // Reset state
        rd(2'd0, 8'h00);
        rd(2'd2, 8'h00);
        rd(2'd3, 8'h00);
        chk("volume_reset", volume, 4'h0);

        // DOC write at $A0
        wr(2'd0, 8'h00);
        wr(2'd2, 8'hA0);
        push_doc(1'b1, 8'hA0, 8'h03);
        exp_lat.push_back(2);
        wr(2'd1, 8'h03);
        idle(4);
        rd(2'd2, 8'hA0);
        rd(2'd3, 8'h00);
        rd(2'd0, 8'h00);

        // DOC read launched off a 7 MHz enable: one wait cycle, old dlatch returned
        wr(2'd2, 8'h55);
        clk_7M_en = 1'b0;
        push_doc(1'b0, 8'h55, 8'h03);
        exp_lat.push_back(3);
        rd(2'd1, 8'h03);
        clk_7M_en = 1'b1;
        idle(5);
        push_doc(1'b0, 8'h55, 8'h09);
        exp_lat.push_back(2);
        rd(2'd1, 8'h09);
        idle(4);

        // RAM reads with auto-increment across $12FF -> $1300
        wr(2'd0, 8'h60);
        wr(2'd3, 8'h12);
        wr(2'd2, 8'hFF);
        exp_lat.push_back(2);
        rd(2'd1, 8'h09);
        idle(4);
        exp_lat.push_back(2);
        rd(2'd1, 8'h5A);
        idle(4);
        rd(2'd2, AI ? 8'h01 : 8'hFF);
        rd(2'd3, AI ? 8'h13 : 8'h12);
        exp_lat.push_back(2);
        rd(2'd1, AI ? 8'hC3 : 8'h5A);
        idle(4);

        // Pointer wrap at $FFFF
        wr(2'd3, 8'hFF);
        wr(2'd2, 8'hFF);
        push_ram(16'hFFFF, 8'h11);
        exp_lat.push_back(2);
        wr(2'd1, 8'h11);
        idle(4);
        rd(2'd2, AI ? 8'h00 : 8'hFF);
        rd(2'd3, AI ? 8'h00 : 8'hFF);

        // Busy drop: back-to-back writes, a write on the clearing cycle, then one after it
        wr(2'd3, 8'h40);
        wr(2'd2, 8'h00);
        push_ram(16'h4000, 8'hA1);
        exp_lat.push_back(2);
        push_ram(AI ? 16'h4001 : 16'h4000, 8'hD4);
        exp_lat.push_back(2);
        wr(2'd1, 8'hA1);
        wr(2'd1, 8'hB2);
        wr(2'd1, 8'hB3);
        wr(2'd1, 8'hD4);
        idle(4);
        rd(2'd2, AI ? 8'h02 : 8'h00);

        // While busy: ADRL write ignored, CTL write changes volume only
        push_ram(AI ? 16'h4002 : 16'h4000, 8'hC5);
        exp_lat.push_back(2);
        wr(2'd1, 8'hC5);
        wr(2'd2, 8'h33);
        wr(2'd0, 8'h0F);
        idle(4);
        rd(2'd0, 8'h6F);
        chk("volume_busy_ctl", volume, 4'hF);
        rd(2'd2, AI ? 8'h03 : 8'h00);

        // Collision with the DOC oscillator slot
        wr(2'd0, 8'h40);
        wr(2'd3, 8'h22);
        wr(2'd2, 8'h22);
        push_ram(16'h2222, 8'h77);
        exp_lat.push_back(3);
        wr(2'd1, 8'h77);
        doc_osc_en = 1'b1;
        idle(1);
        doc_osc_en = 1'b0;
        idle(4);
        rd(2'd2, 8'h22);
        chk("volume_ctl40", volume, 4'h0);

        // Reset during DOC_WAIT
        wr(2'd0, 8'h00);
        wr(2'd2, 8'h5A);
        clk_7M_en = 1'b0;
        exp_lat.push_back(2);
        wr(2'd1, 8'h99);
        idle(1);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        clk_7M_en = 1'b1;
        idle(3);
        rd(2'd0, 8'h00);
        rd(2'd2, 8'h00);
        rd(2'd3, 8'h00);
        chk("volume_after_reset", volume, 4'h0);
        push_doc(1'b0, 8'h00, 8'h00);
        exp_lat.push_back(2);
        rd(2'd1, 8'h00);
        idle(6);

        chk("pending_doc", exp_doc.size(), 0);
        chk("pending_ram", exp_ram.size(), 0);
        chk("pending_rd", exp_rd.size(), 0);
        chk("pending_busy", exp_lat.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
